// File: rtl/board_clk_rst_seq_if.sv
// Sequencer-side signal bundle: SDRAM handshake, core reset, clock enables and status.
// The master modport is the sequencer; the slave modport is the board logic it controls.
interface board_clk_rst_seq_if;
  logic       mem_ready;
  logic       cpu_pause;
  logic       mem_rst;
  logic       sys_reset;
  logic       ce_pix;
  logic       ce_cpu;
  logic [1:0] state;
  logic       fault;

  modport master (
    input  mem_ready,
    input  cpu_pause,
    output mem_rst,
    output sys_reset,
    output ce_pix,
    output ce_cpu,
    output state,
    output fault
  );

  modport slave (
    output mem_ready,
    output cpu_pause,
    input  mem_rst,
    input  sys_reset,
    input  ce_pix,
    input  ce_cpu,
    input  state,
    input  fault
  );
endinterface

// File: rtl/board_clk_rst_seq.sv
// Board reset sequencer for clk_sys: staged SDRAM/core resets with PLL-loss recovery,
// debounced reset keys, SDRAM-init timeout and free-running pixel/CPU clock enables.
module board_clk_rst_seq #(
  parameter int unsigned HOLD_CYCLES = 255,
  parameter int unsigned DEB_CYCLES  = 65535,
  parameter int unsigned NUM_KEYS    = 1,
  parameter int unsigned PIX_DIV     = 4,
  parameter int unsigned CPU_DIV     = 8,
  parameter int unsigned MEM_TIMEOUT = 4096
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic                 locked,
  input  logic [NUM_KEYS-1:0]  key_n,
  board_clk_rst_seq_if.master  seq
);

  localparam int unsigned HoldW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned DebW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned ToW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int unsigned PixW  = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int unsigned DivW  = (CPU_DIV > 1) ? $clog2(CPU_DIV) : 1;

  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);
  localparam logic [DebW-1:0]  DebMax  = DebW'(DEB_CYCLES - 1);
  localparam logic [ToW-1:0]   ToMax   = ToW'(MEM_TIMEOUT - 1);
  localparam logic [PixW-1:0]  PixMax  = PixW'(PIX_DIV - 1);
  localparam logic [DivW-1:0]  DivMax  = DivW'(CPU_DIV - 1);

  typedef enum logic [1:0] {
    StLock = 2'd0,
    StHold = 2'd1,
    StMem  = 2'd2,
    StRun  = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [HoldW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [ToW-1:0]       to_cnt_q, to_cnt_d;
  logic                 fault_q, fault_d;
  logic [1:0]           locked_sync_q;
  logic                 locked_s;
  logic [NUM_KEYS-1:0]  key_meta_q, key_s_q;
  logic [DebW-1:0]      deb_cnt_q [NUM_KEYS];
  logic [DebW-1:0]      deb_cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0]  deb_done_q, deb_done_d;
  logic                 key_press;
  logic [PixW-1:0]      pix_cnt_q, pix_cnt_d;
  logic [DivW-1:0]      div_cnt_q, div_cnt_d;
  logic                 ce_pix_q, ce_cpu_q;

  assign locked_s = locked_sync_q[1];

  // Key synchronisers reset to the released level so reset itself never looks like a press.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      locked_sync_q <= '0;
      key_meta_q    <= '1;
      key_s_q       <= '1;
    end else begin
      locked_sync_q <= {locked_sync_q[0], locked};
      key_meta_q    <= key_n;
      key_s_q       <= key_meta_q;
    end
  end

  always_comb begin
    deb_cnt_d  = deb_cnt_q;
    deb_done_d = deb_done_q;
    key_press  = 1'b0;
    for (int i = 0; i < int'(NUM_KEYS); i++) begin
      if (key_s_q[i]) begin
        deb_cnt_d[i]  = '0;
        deb_done_d[i] = 1'b0;
      end else if (deb_cnt_q[i] == DebMax) begin
        // Saturated: fire once, then stay quiet until the key is seen released.
        if (!deb_done_q[i]) begin
          key_press     = 1'b1;
          deb_done_d[i] = 1'b1;
        end
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_KEYS); i++) begin
        deb_cnt_q[i] <= '0;
      end
      deb_done_q <= '0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      deb_done_q <= deb_done_d;
    end
  end

  // pix_cnt tracks div_cnt mod PIX_DIV since CPU_DIV is a multiple of PIX_DIV.
  always_comb begin
    pix_cnt_d = (pix_cnt_q == PixMax) ? '0 : pix_cnt_q + 1'b1;
    div_cnt_d = (div_cnt_q == DivMax) ? '0 : div_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      pix_cnt_q <= '0;
      div_cnt_q <= '0;
      ce_pix_q  <= 1'b0;
      ce_cpu_q  <= 1'b0;
    end else begin
      pix_cnt_q <= pix_cnt_d;
      div_cnt_q <= div_cnt_d;
      ce_pix_q  <= (pix_cnt_d == PixMax);
      ce_cpu_q  <= (div_cnt_d == DivMax) && !seq.cpu_pause;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    to_cnt_d   = to_cnt_q;
    fault_d    = fault_q;
    if (!locked_s) begin
      state_d = StLock;
    end else if (key_press && (state_q != StLock)) begin
      state_d    = StHold;
      hold_cnt_d = '0;
    end else begin
      unique case (state_q)
        StLock: begin
          state_d    = StHold;
          hold_cnt_d = '0;
        end
        StHold: begin
          if (hold_cnt_q == HoldMax) begin
            state_d  = StMem;
            to_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
        StMem: begin
          if (seq.mem_ready) begin
            state_d = StRun;
          end else if (to_cnt_q == ToMax) begin
            fault_d    = 1'b1;
            state_d    = StHold;
            hold_cnt_d = '0;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
        end
        StRun: state_d = StRun;
        default: state_d = StLock;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= StLock;
      hold_cnt_q <= '0;
      to_cnt_q   <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      to_cnt_q   <= to_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign seq.mem_rst   = (state_q == StLock) || (state_q == StHold);
  assign seq.sys_reset = (state_q != StRun);
  assign seq.ce_pix    = ce_pix_q;
  assign seq.ce_cpu    = ce_cpu_q;
  assign seq.state     = state_q;
  assign seq.fault     = fault_q;

endmodule

// File: tb/tb_board_clk_rst_seq.sv
// Directed bench for board_clk_rst_seq with short hold/debounce/timeout parameters.
module tb_board_clk_rst_seq;
  localparam int unsigned NK = 2;

  logic          clk_sys = 1'b0;
  logic          reset   = 1'b1;
  logic          locked  = 1'b0;
  logic [NK-1:0] key_n   = '1;
  int            errors  = 0;
  int            checks  = 0;

  board_clk_rst_seq_if sif ();

  board_clk_rst_seq #(
    .HOLD_CYCLES (16),
    .DEB_CYCLES  (8),
    .NUM_KEYS    (NK),
    .PIX_DIV     (4),
    .CPU_DIV     (8),
    .MEM_TIMEOUT (32)
  ) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .locked  (locked),
    .key_n   (key_n),
    .seq     (sif)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  // Leaves the bench just after the last reset edge with reset low (start of cycle 1).
  task automatic do_reset(input logic mem_rdy);
    reset         = 1'b1;
    locked        = 1'b1;
    key_n         = '1;
    sif.mem_ready = mem_rdy;
    sif.cpu_pause = 1'b0;
    step(3);
    reset = 1'b0;
  endtask

  task automatic test_reset;
    sif.mem_ready = 1'b0;
    sif.cpu_pause = 1'b0;
    locked        = 1'b1;
    reset         = 1'b1;
    step(4);
    checks++;
    if (sif.mem_rst !== 1'b1) begin
      errors++; $display("FAIL reset_mem_rst got=%b want=1", sif.mem_rst);
    end
    checks++;
    if (sif.sys_reset !== 1'b1) begin
      errors++; $display("FAIL reset_sys_reset got=%b want=1", sif.sys_reset);
    end
    checks++;
    if (sif.ce_pix !== 1'b0 || sif.ce_cpu !== 1'b0) begin
      errors++; $display("FAIL reset_ce got=%b%b want=00", sif.ce_pix, sif.ce_cpu);
    end
    checks++;
    if (sif.state !== 2'd0 || sif.fault !== 1'b0) begin
      errors++; $display("FAIL reset_state got=%0d/%b want=0/0", sif.state, sif.fault);
    end
  endtask

  task automatic test_sequence;
    do_reset(1'b0);
    step(2);
    checks++;
    if (sif.state !== 2'd0) begin
      errors++; $display("FAIL seq_lock_wait state=%0d want=0", sif.state);
    end
    step(1);
    checks++;
    if (sif.state !== 2'd1) begin
      errors++; $display("FAIL seq_hold_entry state=%0d want=1", sif.state);
    end
    step(15);
    checks++;
    if (sif.state !== 2'd1 || sif.mem_rst !== 1'b1) begin
      errors++; $display("FAIL seq_hold_end state=%0d mem_rst=%b want=1/1", sif.state, sif.mem_rst);
    end
    step(1);
    checks++;
    if (sif.state !== 2'd2 || sif.mem_rst !== 1'b0 || sif.sys_reset !== 1'b1) begin
      errors++; $display("FAIL seq_mem_entry state=%0d mem_rst=%b sys_reset=%b want=2/0/1",
                         sif.state, sif.mem_rst, sif.sys_reset);
    end
    step(10);
    checks++;
    if (sif.sys_reset !== 1'b1) begin
      errors++; $display("FAIL seq_mem_wait sys_reset=%b want=1", sif.sys_reset);
    end
    sif.mem_ready = 1'b1;
    step(1);
    checks++;
    if (sif.state !== 2'd3 || sif.sys_reset !== 1'b0 || sif.mem_rst !== 1'b0 || sif.fault !== 1'b0)
    begin
      errors++; $display("FAIL seq_run_entry state=%0d sys_reset=%b mem_rst=%b fault=%b want=3/0/0/0",
                         sif.state, sif.sys_reset, sif.mem_rst, sif.fault);
    end
  endtask

  task automatic test_divider;
    logic exp_pix, exp_cpu;
    do_reset(1'b0);
    for (int c = 1; c <= 24; c++) begin
      sif.cpu_pause = (c >= 14 && c <= 16);
      exp_pix = (c % 4 == 0);
      exp_cpu = (c % 8 == 0) && (c != 16);
      checks++;
      if (sif.ce_pix !== exp_pix) begin
        errors++; $display("FAIL div_ce_pix cycle=%0d got=%b want=%b", c, sif.ce_pix, exp_pix);
      end
      checks++;
      if (sif.ce_cpu !== exp_cpu) begin
        errors++; $display("FAIL div_ce_cpu cycle=%0d got=%b want=%b", c, sif.ce_cpu, exp_cpu);
      end
      step(1);
    end
    sif.cpu_pause = 1'b0;
  endtask

  task automatic test_debounce;
    int n;
    do_reset(1'b1);
    n = 0;
    while (sif.state !== 2'd3 && n < 40) begin
      step(1);
      n++;
    end
    checks++;
    if (sif.state !== 2'd3) begin
      errors++; $display("FAIL deb_bring_up state=%0d want=3", sif.state);
    end
    key_n[0] = 1'b0;
    step(3);
    key_n[0] = 1'b1;
    step(12);
    checks++;
    if (sif.state !== 2'd3) begin
      errors++; $display("FAIL deb_short_press state=%0d want=3", sif.state);
    end
    key_n[1] = 1'b0;
    step(9);
    checks++;
    if (sif.state !== 2'd3) begin
      errors++; $display("FAIL deb_before_event state=%0d want=3", sif.state);
    end
    step(1);
    checks++;
    if (sif.state !== 2'd1 || sif.mem_rst !== 1'b1 || sif.sys_reset !== 1'b1) begin
      errors++; $display("FAIL deb_event state=%0d mem_rst=%b sys_reset=%b want=1/1/1",
                         sif.state, sif.mem_rst, sif.sys_reset);
    end
    step(10);
    key_n[1] = 1'b1;
    step(5);
    checks++;
    if (sif.state !== 2'd1) begin
      errors++; $display("FAIL deb_hold_end state=%0d want=1", sif.state);
    end
    step(1);
    checks++;
    if (sif.state !== 2'd2) begin
      errors++; $display("FAIL deb_single_event state=%0d want=2", sif.state);
    end
    step(1);
    checks++;
    if (sif.state !== 2'd3) begin
      errors++; $display("FAIL deb_rerun state=%0d want=3", sif.state);
    end
  endtask

  task automatic test_lock_loss;
    locked = 1'b0;
    step(2);
    checks++;
    if (sif.state !== 2'd3) begin
      errors++; $display("FAIL lock_sync_delay state=%0d want=3", sif.state);
    end
    step(1);
    checks++;
    if (sif.state !== 2'd0 || sif.mem_rst !== 1'b1 || sif.sys_reset !== 1'b1) begin
      errors++; $display("FAIL lock_drop state=%0d mem_rst=%b sys_reset=%b want=0/1/1",
                         sif.state, sif.mem_rst, sif.sys_reset);
    end
    step(3);
    locked = 1'b1;
    step(2);
    checks++;
    if (sif.state !== 2'd0) begin
      errors++; $display("FAIL relock_wait state=%0d want=0", sif.state);
    end
    step(1);
    checks++;
    if (sif.state !== 2'd1) begin
      errors++; $display("FAIL relock_hold state=%0d want=1", sif.state);
    end
    step(16);
    checks++;
    if (sif.state !== 2'd2) begin
      errors++; $display("FAIL relock_mem state=%0d want=2", sif.state);
    end
    step(1);
    checks++;
    if (sif.state !== 2'd3 || sif.fault !== 1'b0) begin
      errors++; $display("FAIL relock_run state=%0d fault=%b want=3/0", sif.state, sif.fault);
    end
  endtask

  task automatic test_timeout;
    do_reset(1'b0);
    step(19);
    checks++;
    if (sif.state !== 2'd2 || sif.fault !== 1'b0) begin
      errors++; $display("FAIL to_mem_entry state=%0d fault=%b want=2/0", sif.state, sif.fault);
    end
    step(31);
    checks++;
    if (sif.state !== 2'd2 || sif.fault !== 1'b0) begin
      errors++; $display("FAIL to_last_wait state=%0d fault=%b want=2/0", sif.state, sif.fault);
    end
    step(1);
    checks++;
    if (sif.state !== 2'd1 || sif.fault !== 1'b1 || sif.mem_rst !== 1'b1) begin
      errors++; $display("FAIL to_expire state=%0d fault=%b mem_rst=%b want=1/1/1",
                         sif.state, sif.fault, sif.mem_rst);
    end
    step(16);
    checks++;
    if (sif.state !== 2'd2 || sif.fault !== 1'b1) begin
      errors++; $display("FAIL to_retry state=%0d fault=%b want=2/1", sif.state, sif.fault);
    end
    step(3);
    sif.mem_ready = 1'b1;
    step(1);
    checks++;
    if (sif.state !== 2'd3 || sif.fault !== 1'b1) begin
      errors++; $display("FAIL to_run_sticky state=%0d fault=%b want=3/1", sif.state, sif.fault);
    end
    sif.mem_ready = 1'b0;
    step(5);
    checks++;
    if (sif.state !== 2'd3) begin
      errors++; $display("FAIL run_mem_ready_drop state=%0d want=3", sif.state);
    end
  endtask

  task automatic test_reset_mid_mem;
    key_n[0] = 1'b0;
    step(12);
    key_n[0] = 1'b1;
    step(18);
    checks++;
    if (sif.state !== 2'd2 || sif.fault !== 1'b1) begin
      errors++; $display("FAIL mid_mem_setup state=%0d fault=%b want=2/1", sif.state, sif.fault);
    end
    reset = 1'b1;
    step(1);
    checks++;
    if (sif.state !== 2'd0 || sif.fault !== 1'b0 || sif.mem_rst !== 1'b1 ||
        sif.sys_reset !== 1'b1 || sif.ce_pix !== 1'b0 || sif.ce_cpu !== 1'b0) begin
      errors++; $display("FAIL mid_mem_reset state=%0d fault=%b mem_rst=%b sys_reset=%b ce=%b%b want=0/0/1/1/00",
                         sif.state, sif.fault, sif.mem_rst, sif.sys_reset, sif.ce_pix, sif.ce_cpu);
    end
    reset = 1'b0;
    step(19);
    checks++;
    if (sif.state !== 2'd2 || sif.fault !== 1'b0) begin
      errors++; $display("FAIL mid_mem_rerun state=%0d fault=%b want=2/0", sif.state, sif.fault);
    end
  endtask

  initial begin
    sif.mem_ready = 1'b0;
    sif.cpu_pause = 1'b0;
    test_reset();
    test_sequence();
    test_divider();
    test_debounce();
    test_lock_loss();
    test_timeout();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
